// File: rtl/dmem_responder_if.sv
// Request/response bundle between the control unit and the data-memory responder.
// Latency: none, wires only.
// Backpressure: the requester holds its strobe until done; busy shows the responder is occupied.
interface dmem_responder_if;
  logic        memread;
  logic        memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  // Requester side: drives strobes and operands, observes the response.
  modport master (
    output memread, memwrite, funct3, addr, wdata,
    input  rdata, busy, done, err
  );

  // Responder side: observes the request, drives the response.
  modport slave (
    input  memread, memwrite, funct3, addr, wdata,
    output rdata, busy, done, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM with RV32I byte/half/word loads and stores.
// Latency: request seen in IDLE at cycle N -> done pulse in cycle N+2+WAIT_CYCLES.
// Backpressure: busy is high outside IDLE; strobes are only sampled in IDLE.
// Optional misalignment trap compiled in with DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM and latched request
  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              mis_q, mis_d;
  logic [31:0]       rdata_q, rdata_d;

  // Raw word captured on the ACCESS edge of a load
  logic [31:0]       rword_q;

  logic [31:0]       mem [0:DEPTH-1];

  logic              req;
  logic              in_half, in_byte, in_word;
  logic              mis_in;
  logic [ADDR_W-1:0] idx;
  logic              q_half, q_byte;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic              wr_fire, rd_fire;
  logic              load_ok;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       load_val;

  // Address bits above the RAM are deliberately ignored (wrap modulo depth)
  logic              unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  assign req = bus.memread | bus.memwrite;

  // Classify the incoming access size; undefined encodings fall back to word
  always_comb begin
    in_half = (bus.funct3 == F3_H) || (bus.funct3 == F3_HU);
    in_byte = (bus.funct3 == F3_B) || (bus.funct3 == F3_BU);
    in_word = !in_half && !in_byte;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_in = (in_half && bus.addr[0]) || (in_word && (bus.addr[1:0] != 2'b00));
`else
  // Misaligned addresses are simply forced aligned by the lane logic below
  assign mis_in = 1'b0;
  logic unused_size;
  assign unused_size = in_word;
`endif

  assign idx    = addr_q[ADDR_W+1:2];
  assign q_half = (funct3_q == F3_H) || (funct3_q == F3_HU);
  assign q_byte = (funct3_q == F3_B) || (funct3_q == F3_BU);

  // Byte enables and lane-replicated store data from the latched request
  always_comb begin
    be = 4'b1111;
    wd = wdata_q;
    if (q_byte) begin
      be = 4'b0001 << addr_q[1:0];
      wd = {4{wdata_q[7:0]}};
    end else if (q_half) begin
      be = addr_q[1] ? 4'b1100 : 4'b0011;
      wd = {2{wdata_q[15:0]}};
    end
  end

  assign wr_fire = (state_q == S_ACCESS) &&  wr_q && !mis_q;
  assign rd_fire = (state_q == S_ACCESS) && !wr_q && !mis_q;
  assign load_ok = !wr_q && !mis_q;

  // Store: byte-enabled write on the clock edge leaving ACCESS (RAM is never reset)
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Load: capture the full word on the clock edge leaving ACCESS
  always_ff @(posedge clk) begin
    if (rd_fire) rword_q <= mem[idx];
  end

  // Lane select and sign/zero extension of the captured word
  always_comb begin
    ld_byte  = rword_q[8*addr_q[1:0] +: 8];
    ld_half  = addr_q[1] ? rword_q[31:16] : rword_q[15:0];
    case (funct3_q)
      F3_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_val = {24'd0, ld_byte};
      F3_H:    load_val = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_val = {16'd0, ld_half};
      default: load_val = rword_q;
    endcase
  end

  // Next-state logic: request latch, wait countdown, response
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    mis_d    = mis_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d  = S_ACCESS;
          addr_d   = bus.addr[ADDR_W+1:0];
          funct3_d = bus.funct3;
          wdata_d  = bus.wdata;
          wr_d     = bus.memwrite;   // write wins when both strobes are high
          mis_d    = mis_in;
        end
      end
      S_ACCESS: begin
        if (WAIT_CYCLES == 0) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (load_ok) rdata_d = load_val;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any in-flight access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      funct3_q <= 3'd0;
      wdata_q  <= 32'd0;
      wr_q     <= 1'b0;
      mis_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      mis_q    <= mis_d;
      rdata_q  <= rdata_d;
    end
  end

  // The new load value is presented from RESP entry and held afterwards by rdata_q
  assign bus.rdata = ((state_q == S_RESP) && load_ok) ? load_val : rdata_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = (state_q == S_RESP);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign bus.err   = (state_q == S_RESP) && mis_q;
`else
  assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: loads/stores, extension, latency, misalignment, reset abort.
// Latency: checks done at N+2+WAIT_CYCLES for WAIT_CYCLES = 0, 1, 3.
// Backpressure: one-cycle strobes, next request only after done.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int done0_cyc = 0;
  int done3_cyc = 0;
  logic [31:0] last_rd = 32'd0;

  dmem_responder_if bus1 ();
  dmem_responder_if bus0 ();
  dmem_responder_if bus3 ();

  assign bus1.memread = memread;  assign bus1.memwrite = memwrite;
  assign bus1.funct3  = funct3;   assign bus1.addr     = addr;
  assign bus1.wdata   = wdata;
  assign bus0.memread = memread;  assign bus0.memwrite = memwrite;
  assign bus0.funct3  = funct3;   assign bus0.addr     = addr;
  assign bus0.wdata   = wdata;
  assign bus3.memread = memread;  assign bus3.memwrite = memwrite;
  assign bus3.funct3  = funct3;   assign bus3.addr     = addr;
  assign bus3.wdata   = wdata;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) dut  (.clk(clk), .reset(reset), .bus(bus1));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // First done pulse of the WAIT_CYCLES=0 and =3 instances
  always @(negedge clk) begin
    if (bus0.done && done0_cyc == 0) done0_cyc = cyc;
    if (bus3.done && done3_cyc == 0) done3_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request with a one-cycle strobe; reports response seen on the main instance
  task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    output logic [31:0] o_rd, output logic o_err, output int o_lat,
                    output logic o_busy1, output logic o_busyr, output int o_req);
    bit seen;
    seen = 0; o_rd = 32'd0; o_err = 1'b0; o_lat = 99; o_busy1 = 1'b0; o_busyr = 1'b0;
    @(posedge clk); #1;
    memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd;
    o_req = cyc;
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) o_busy1 = bus1.busy;
      if (bus1.done) begin
        seen = 1; o_rd = bus1.rdata; o_err = bus1.err; o_busyr = bus1.busy;
        o_lat = cyc - o_req;
      end
    end
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d; logic e, b1, br; int lat, rq;
    op(1'b1, 1'b0, f3, a, 32'd0, d, e, lat, b1, br, rq);
    if (!exp_e) last_rd = exp_d;
    check({tag, "_rdata"}, d, last_rd);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
    check({tag, "_lat"}, lat, 32'd3);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic exp_e);
    logic [31:0] d; logic e, b1, br; int lat, rq;
    op(1'b0, 1'b1, f3, a, wd, d, e, lat, b1, br, rq);
    check({tag, "_rdata_hold"}, d, last_rd);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
    check({tag, "_lat"}, lat, 32'd3);
  endtask

  initial begin
    logic [31:0] d; logic e, b1, br; int lat, rq; bit seen;
    logic trap;
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rdata", bus1.rdata, 32'd0);
    check("rst_done", {31'd0, bus1.done}, 32'd0);
    check("rst_busy", {31'd0, bus1.busy}, 32'd0);
    check("rst_err", {31'd0, bus1.err}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (2) @(posedge clk);

    // SW 0xDEADBEEF at 0x10, latency on all three instances
    op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e, lat, b1, br, rq);
    check("sw10_lat_w1", lat, 32'd3);
    check("sw10_busy_n1", {31'd0, b1}, 32'd1);
    check("sw10_busy_resp", {31'd0, br}, 32'd1);
    repeat (5) @(posedge clk);
    check("lat_w0", done0_cyc, rq + 2);
    check("lat_w3", done3_cyc, rq + 5);
    do_load("lw10", 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);

    // Byte store / loads
    do_store("sw20", 3'b010, 32'h20, 32'h11223344, 1'b0);
    do_store("sb21", 3'b000, 32'h21, 32'h12345680, 1'b0);
    do_load("lb21",  3'b000, 32'h21, 32'hFFFFFF80, 1'b0);
    do_load("lbu21", 3'b100, 32'h21, 32'h00000080, 1'b0);
    do_load("lw20",  3'b010, 32'h20, 32'h11228044, 1'b0);

    // Halfword store / loads
    do_store("sw30", 3'b010, 32'h30, 32'hAABBCCDD, 1'b0);
    do_store("sh32", 3'b001, 32'h32, 32'hFFFF8001, 1'b0);
    do_load("lh32",  3'b001, 32'h32, 32'hFFFF8001, 1'b0);
    do_load("lhu32", 3'b101, 32'h32, 32'h00008001, 1'b0);
    do_load("lh30",  3'b001, 32'h30, 32'hFFFFCCDD, 1'b0);
    do_load("lhu30", 3'b101, 32'h30, 32'h0000CCDD, 1'b0);
    // Address wrap: 0x1030 aliases word 0x30 with 1K words
    do_load("lw_wrap", 3'b010, 32'h1030, 32'h8001CCDD, 1'b0);

    // Misaligned accesses
    do_load("lw13", 3'b010, 32'h13, 32'hDEADBEEF, trap);
    do_store("sw11", 3'b010, 32'h11, 32'h55555555, trap);
    do_load("lw10b", 3'b010, 32'h10, trap ? 32'hDEADBEEF : 32'h55555555, 1'b0);
    do_load("lh33", 3'b001, 32'h33, 32'hFFFF8001, trap);

    // Both strobes: write only, rdata must hold
    op(1'b1, 1'b1, 3'b010, 32'h40, 32'h0BADF00D, d, e, lat, b1, br, rq);
    check("both_rdata_hold", d, last_rd);
    check("both_lat", lat, 32'd3);
    do_load("lw40", 3'b010, 32'h40, 32'h0BADF00D, 1'b0);

    // Reset during WAIT aborts the load
    do_store("sw50", 3'b010, 32'h50, 32'h11111111, 1'b0);
    @(posedge clk); #1;
    memread = 1'b1; funct3 = 3'b010; addr = 32'h50;
    @(posedge clk); #1; memread = 1'b0;
    @(posedge clk); #1;
    check("wait_busy_pre", {31'd0, bus1.busy}, 32'd1);
    reset = 1'b1; #1;
    check("abort_rdata", bus1.rdata, 32'd0);
    check("abort_busy", {31'd0, bus1.busy}, 32'd0);
    check("abort_done", {31'd0, bus1.done}, 32'd0);
    check("abort_err", {31'd0, bus1.err}, 32'd0);
    last_rd = 32'd0;
    repeat (2) @(posedge clk); #1; reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus1.done) seen = 1;
    end
    check("abort_no_done", {31'd0, seen}, 32'd0);

    // Store blocked by reset while in ACCESS (before its write edge)
    @(posedge clk); #1;
    memwrite = 1'b1; funct3 = 3'b010; addr = 32'h50; wdata = 32'h22222222;
    @(posedge clk); #1; memwrite = 1'b0; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    do_load("lw50", 3'b010, 32'h50, 32'h11111111, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving the multi-cycle control unit's memread/memwrite strobes during the Load and Store phases. Contains a word-organised synchronous RAM and performs RV32I byte, halfword and word accesses with load sign/zero extension. Each request is accepted, serviced over a fixed number of cycles, and signalled complete with a one-cycle done pulse.

Parameters:
ADDR_W, 10, word-address bits; RAM depth is 2^ADDR_W 32-bit words.
WAIT_CYCLES, 1, extra wait states between access and response; legal range 0..15.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
memread  in  1  load request; sampled only in IDLE
memwrite  in  1  store request; sampled only in IDLE
funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  byte address from the ALU result
wdata  in  32  store data (rs2); low byte/half used for SB/SH
rdata  out  32  extended load result; holds until the next load completes
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  misalignment flag; tied 0 unless the optional feature is compiled in

Behaviour:
- Reset (asynchronous): state=IDLE, rdata=0, done=0, busy=0, err=0. RAM contents are not reset.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: on memread|memwrite, latch addr, funct3, wdata and op, then go to ACCESS.
  - If memread and memwrite are both high, memwrite wins and no read is performed.
- ACCESS: the RAM operation occurs on the clock edge leaving this state.
  - Store: write with byte enables.
  - Load: read the full word into an internal register.
  - Next state is RESP if WAIT_CYCLES=0; otherwise WAIT, with the counter loaded to WAIT_CYCLES-1.
- WAIT: decrement the counter each cycle; at 0, go to RESP.
- RESP: done=1 for exactly this cycle.
  - For a load, rdata is updated on entry to RESP, so it is valid while done=1.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle N gives done high in cycle N+2+WAIT_CYCLES.
- Request handshake: the requester must drop its strobe by the done cycle. A strobe still high in IDLE is accepted as a new request.
- Addressing:
  - Word index = addr[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo depth.
  - Byte lane = addr[1:0]; halfword select = addr[1].
- Store byte enables:
  - SB: lane addr[1:0], data wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1}, data wdata[15:0].
  - SW: all four lanes.
- Load extraction:
  - Select the byte or halfword, then sign-extend for funct3 000/001 or zero-extend for 100/101.
  - LW returns the full word.
- Undefined funct3 (011, 110, 111): access is treated as a word access.
- Alignment without the optional feature: low address bits are forced aligned (H ignores addr[0]; W ignores addr[1:0]).
- Reset mid-operation aborts the access. A write whose ACCESS edge has not occurred is not performed.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined: an H access with addr[0]=1, or a W access with addr[1:0]≠0, suppresses the RAM write and leaves rdata unchanged. err=1 in the RESP cycle, coincident with done; err is 0 at all other times. The timing is otherwise identical.
- Undefined: misaligned addresses are forced aligned as described under Behaviour, and err is constant 0.

Test Plan:
- SW wdata=0xDEADBEEF at addr 0x10, then LW at 0x10 -> rdata=0xDEADBEEF with done; busy high from N+1 through RESP.
- SB 0x80 at 0x21, then LB at 0x21 -> 0xFFFFFF80; LBU at 0x21 -> 0x00000080; LW at 0x20 shows only byte lane 1 changed.
- SH 0x8001 at 0x32, then LH at 0x32 -> 0xFFFF8001; LHU -> 0x00008001; LH at 0x30 returns the untouched low half.
- WAIT_CYCLES=3: memread in cycle N -> done exactly in cycle N+5; with WAIT_CYCLES=0 -> done in cycle N+2.
- Misaligned LW at 0x13:
  - Feature off -> returns the word at 0x10, err=0.
  - Feature on -> err=1 with done, rdata unchanged.
  - Misaligned SW with feature on -> memory unchanged.
- Reset asserted during WAIT -> outputs are 0 immediately and done never pulses. A pending store blocked by reset before ACCESS leaves the target word unchanged. memread and memwrite both high -> only the write occurs.
